instruction_fetch: RTL and testbench

Fetch stage of the RV64 core. It holds the program counter, issues 32-bit instruction reads to instruction memory over a request/grant/response handshake, and presents each fetched instruction with its PC to decode over a valid/ready handshake. Decode feeds the instruction to `immediate_generator`. Downstream branch/jump logic redirects the PC through a single-cycle redirect port.

---
 rtl/instruction_fetch_if.sv | 39 +++
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode
// valid/ready hand-off, and the single-cycle PC redirect port.
interface instruction_fetch_if #(
  parameter int unsigned PCSIZE    = 64,
  parameter int unsigned INSTRSIZE = 32
);
  logic                 imem_req;
  logic [PCSIZE-1:0]    imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTRSIZE-1:0] imem_rdata;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTRSIZE-1:0] instruction;
  logic [PCSIZE-1:0]    instr_pc;
  logic                 instr_misaligned;

  logic                 redirect_valid;
  logic [PCSIZE-1:0]    redirect_pc;

  // Fetch-stage side.
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instruction, instr_pc, instr_misaligned,
    input  instr_ready,
    input  redirect_valid, redirect_pc
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instruction, instr_pc, instr_misaligned,
    output instr_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV64 fetch stage: owns the PC, issues one outstanding 32-bit read at a time
// and hands each instruction (or a misaligned-PC marker) to decode.
module instruction_fetch #(
  parameter int unsigned       PCSIZE    = 64,
  parameter int unsigned       INSTRSIZE = 32,
  parameter logic [PCSIZE-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam logic [INSTRSIZE-1:0] NOP = INSTRSIZE'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t               state,     state_n;
  logic [PCSIZE-1:0]    pc,        pc_n;
  logic                 kill,      kill_n;
  logic                 valid_q,   valid_n;
  logic [INSTRSIZE-1:0] instr_q,   instr_n;
  logic [PCSIZE-1:0]    ipc_q,     ipc_n;
  logic                 mis_q,     mis_n;

  logic aligned;
  assign aligned = (pc[1:0] == 2'b00);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    valid_n = valid_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    mis_n   = mis_q;

    case (state)
      IDLE: state_n = FETCH;

      FETCH: begin
        if (aligned) begin
          if (bus.imem_gnt) begin
            state_n = WAIT;
            kill_n  = bus.redirect_valid;
          end
        end else if (!bus.redirect_valid) begin
          // A redirect wins over the misaligned marker: the new PC is retried.
          valid_n = 1'b1;
          instr_n = NOP;
          ipc_n   = pc;
          mis_n   = 1'b1;
          state_n = HOLD;
        end
      end

      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill || bus.redirect_valid) begin
            kill_n  = 1'b0;
            state_n = FETCH;
          end else begin
            valid_n = 1'b1;
            instr_n = bus.imem_rdata;
            ipc_n   = pc;
            mis_n   = 1'b0;
            pc_n    = pc + PCSIZE'(4);
            state_n = HOLD;
          end
        end else if (bus.redirect_valid) begin
          kill_n = 1'b1;
        end
      end

      HOLD: begin
        if (bus.instr_ready || bus.redirect_valid) begin
          valid_n = 1'b0;
          state_n = FETCH;
        end
      end

      default: state_n = IDLE;
    endcase

    if (bus.redirect_valid) pc_n = bus.redirect_pc;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP;
      ipc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      kill    <= kill_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
      mis_q   <= mis_n;
    end
  end

  assign bus.imem_req         = (state == FETCH) && aligned;
  assign bus.imem_addr        = pc;
  assign bus.instr_valid      = valid_q;
  assign bus.instruction      = instr_q;
  assign bus.instr_pc         = ipc_q;
  assign bus.instr_misaligned = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model plus request and
// decode scoreboards checked by a negedge monitor.
module tb_instruction_fetch;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_instr_t;

  logic clk;
  logic rst;

  instruction_fetch_if #(.PCSIZE(64), .INSTRSIZE(32)) bus ();

  instruction_fetch #(
    .PCSIZE   (64),
    .INSTRSIZE(32),
    .RESET_PC (64'h1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  exp_instr_t  exp_instr_q[$];
  logic [63:0] exp_req_q[$];

  int          resp_delay = 0;
  logic        pending    = 1'b0;
  logic [63:0] p_addr;
  int          p_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    case (addr)
      64'h0000_0000_0000_1000: return 32'h00F0_8713;
      64'h0000_0000_0000_1004: return 32'hFCE0_8713;
      64'h0000_0000_0000_1008: return 32'h0010_0093;
      64'h0000_0000_0000_100C: return 32'hDEAD_BEEF;
      64'h0000_0000_0000_2000: return 32'h0020_0113;
      64'h0000_0000_0000_3000: return 32'h0030_0193;
      64'h0000_0000_0000_4000: return 32'h0040_0213;
      64'h0000_0000_0000_4004: return 32'h0050_0293;
      64'hFFFF_FFFF_FFFF_FFFC: return 32'h0000_006F;
      64'h0000_0000_0000_0000: return 32'h0000_0517;
      default:                 return 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic push_instr(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
    exp_instr_t e;
    e.pc    = pc;
    e.instr = instr;
    e.mis   = mis;
    exp_instr_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.instr_valid !== 1'b1) check("wait_valid_timeout", {63'd0, bus.instr_valid}, 64'd1);
  endtask

  // Memory model: ignores reset on purpose so a late response can arrive.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
        pending = 1'b1;
        p_addr  = bus.imem_addr;
        p_cnt   = resp_delay;
      end
      @(posedge clk);
      #1;
      if (pending && p_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(p_addr);
        pending         = 1'b0;
      end else begin
        bus.imem_rvalid = 1'b0;
        if (pending) p_cnt--;
      end
    end
  end

  // Monitor: pops the scoreboards on each granted request and each decode handshake.
  initial begin
    exp_instr_t  e;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", bus.imem_addr, 64'hXXXX_XXXX_XXXX_XXXX);
        end else begin
          a = exp_req_q.pop_front();
          check("req_addr", bus.imem_addr, a);
        end
      end
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        if (exp_instr_q.size() == 0) begin
          check("unexpected_instr", {32'd0, bus.instruction}, 64'hXXXX_XXXX_XXXX_XXXX);
        end else begin
          e = exp_instr_q.pop_front();
          check("instr_pc", bus.instr_pc, e.pc);
          check("instruction", {32'd0, bus.instruction}, {32'd0, e.instr});
          check("instr_misaligned", {63'd0, bus.instr_misaligned}, {63'd0, e.mis});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst                = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state.
    tick();
    tick();
    check("rst_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("rst_instruction", {32'd0, bus.instruction}, 64'h13);
    check("rst_instr_pc", bus.instr_pc, 64'd0);
    check("rst_misaligned", {63'd0, bus.instr_misaligned}, 64'd0);
    check("rst_req", {63'd0, bus.imem_req}, 64'd0);

    // Back-to-back fetch from RESET_PC, decode always ready.
    exp_req_q.push_back(64'h1000);
    exp_req_q.push_back(64'h1004);
    push_instr(64'h1000, 32'h00F0_8713, 1'b0);
    push_instr(64'h1004, 32'hFCE0_8713, 1'b0);
    rst = 1'b0;
    check("idle_no_req", {63'd0, bus.imem_req}, 64'd0);
    tick();
    check("first_req", {63'd0, bus.imem_req}, 64'd1);
    check("first_addr", bus.imem_addr, 64'h1000);
    wait_valid(20, n);
    check("first_latency", 64'(n), 64'd2);
    tick();
    wait_valid(20, n);
    check("spacing", 64'(n + 1), 64'd3);
    bus.imem_gnt = 1'b0;

    // Decode stall: output held, no new request.
    tick();
    bus.instr_ready = 1'b0;
    exp_req_q.push_back(64'h1008);
    push_instr(64'h1008, 32'h0010_0093, 1'b0);
    bus.imem_gnt = 1'b1;
    wait_valid(20, n);
    bus.imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {63'd0, bus.instr_valid}, 64'd1);
      check("stall_instruction", {32'd0, bus.instruction}, 64'h0010_0093);
      check("stall_pc", bus.instr_pc, 64'h1008);
      check("stall_req", {63'd0, bus.imem_req}, 64'd0);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("after_stall_req", {63'd0, bus.imem_req}, 64'd1);
    check("after_stall_addr", bus.imem_addr, 64'h100C);
    check("after_stall_valid", {63'd0, bus.instr_valid}, 64'd0);

    // Grant withheld: request held stable.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nogrant_req", {63'd0, bus.imem_req}, 64'd1);
      check("nogrant_addr", bus.imem_addr, 64'h100C);
    end

    // Redirect during WAIT: late 0xDEADBEEF response is dropped.
    exp_req_q.push_back(64'h100C);
    resp_delay   = 2;
    bus.imem_gnt = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2000;
    exp_req_q.push_back(64'h2000);
    push_instr(64'h2000, 32'h0020_0113, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    resp_delay         = 0;
    check("kill_wait_valid", {63'd0, bus.instr_valid}, 64'd0);
    tick();
    check("kill_wait_req", {63'd0, bus.imem_req}, 64'd0);
    tick();
    check("redirect_req", {63'd0, bus.imem_req}, 64'd1);
    check("redirect_addr", bus.imem_addr, 64'h2000);
    check("redirect_no_valid", {63'd0, bus.instr_valid}, 64'd0);
    wait_valid(20, n);

    // Redirect in HOLD with ready the same cycle.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    exp_req_q.push_back(64'h3000);
    push_instr(64'h3000, 32'h0030_0193, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    check("hold_redir_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("hold_redir_req", {63'd0, bus.imem_req}, 64'd1);
    check("hold_redir_addr", bus.imem_addr, 64'h3000);
    wait_valid(20, n);

    // Misaligned target: marker emitted, then re-emitted, no request.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2002;
    push_instr(64'h2002, 32'h0000_0013, 1'b1);
    push_instr(64'h2002, 32'h0000_0013, 1'b1);
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_no_req", {63'd0, bus.imem_req}, 64'd0);
    tick();
    check("mis_valid", {63'd0, bus.instr_valid}, 64'd1);
    tick();
    check("mis_again_no_req", {63'd0, bus.imem_req}, 64'd0);
    tick();
    check("mis_again_valid", {63'd0, bus.instr_valid}, 64'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    exp_req_q.push_back(64'h4000);
    push_instr(64'h4000, 32'h0040_0213, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    check("resume_req", {63'd0, bus.imem_req}, 64'd1);
    check("resume_addr", bus.imem_addr, 64'h4000);
    wait_valid(20, n);
    bus.imem_gnt = 1'b0;
    tick();
    check("next_addr", bus.imem_addr, 64'h4004);

    // Reset during WAIT with a late response.
    resp_delay = 3;
    exp_req_q.push_back(64'h4004);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("rst2_req", {63'd0, bus.imem_req}, 64'd0);
    check("rst2_instr_pc", bus.instr_pc, 64'd0);
    tick();
    check("rst2_req_on", {63'd0, bus.imem_req}, 64'd1);
    check("rst2_addr", bus.imem_addr, 64'h1000);
    tick();
    tick();
    check("late_resp_valid", {63'd0, bus.instr_valid}, 64'd0);
    check("late_resp_req", {63'd0, bus.imem_req}, 64'd1);
    check("late_resp_addr", bus.imem_addr, 64'h1000);
    resp_delay = 0;
    exp_req_q.push_back(64'h1000);
    push_instr(64'h1000, 32'h00F0_8713, 1'b0);
    bus.imem_gnt = 1'b1;
    wait_valid(20, n);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req_q.push_back(64'h0);
    push_instr(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_006F, 1'b0);
    push_instr(64'h0, 32'h0000_0517, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    wait_valid(20, n);
    tick();
    wait_valid(20, n);
    bus.imem_gnt = 1'b0;
    tick();
    check("wrap_next_addr", bus.imem_addr, 64'h4);

    for (int i = 0; i < 4; i++) tick();
    check("instr_queue_drained", 64'(exp_instr_q.size()), 64'd0);
    check("req_queue_drained", 64'(exp_req_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
